// File: rtl/mp_pkg.sv
// ---------------------------------------------------------------------------
// mp_pkg
// Shared definitions for the multi-precision add/subtract sequencer:
//   MP_N      - default datapath word width in bits
//   MP_WORDS  - default maximum operand length in words
//   word_t    - one datapath word
//   state_t   - sequencer FSM encoding (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package mp_pkg;

    localparam int MP_N     = 32;
    localparam int MP_WORDS = 32;

    typedef logic [MP_N-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mp_pkg

// File: rtl/mp_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// mp_add_sequencer_if
// Bundles the core handshake and scratch-RAM port of the sequencer.
//   Core side : start, op_sub, len, abort  -> sequencer
//               busy, done, carry_out      <- sequencer
//   RAM side  : a_word, b_word             -> sequencer (read data, 1-cycle latency)
//               rd_en, rd_addr             <- sequencer (read request)
//               wr_en, wr_addr, wr_data    <- sequencer (result write)
// Modports:
//   master - the execute stage / RAM environment driving the sequencer
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface mp_add_sequencer_if #(
    parameter int N  = mp_pkg::MP_N,
    parameter int AW = $clog2(mp_pkg::MP_WORDS)
) ();

    logic          start;
    logic          op_sub;
    logic [AW:0]   len;
    logic          abort;
    logic [N-1:0]  a_word;
    logic [N-1:0]  b_word;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          busy;
    logic          done;
    logic          carry_out;

    modport master (
        output start, op_sub, len, abort, a_word, b_word,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, carry_out
    );

    modport slave (
        input  start, op_sub, len, abort, a_word, b_word,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, carry_out
    );

endinterface : mp_add_sequencer_if

// File: rtl/adder_cin.sv
// ---------------------------------------------------------------------------
// adder_cin
// Combinational N-bit adder with carry in and carry out.
//   a, b  - addends
//   cin   - carry in
//   sum   - low N bits of a + b + cin
//   cout  - bit N of a + b + cin
// ---------------------------------------------------------------------------
module adder_cin #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule : adder_cin

// File: rtl/mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// mp_add_sequencer
// Performs a multi-word add or subtract by streaming operand word pairs from
// a synchronous scratch RAM through one N-bit adder, least significant word
// first, rippling the carry/borrow between words in a register and writing
// each result word back one cycle after its read.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - mp_add_sequencer_if.slave (core handshake + RAM read/write port)
//
// Timing for an accepted start at edge T0 with len >= 1:
//   reads in cycles 1..len, writes in cycles 2..len+1,
//   busy in cycles 1..len+1, done pulse in cycle len+2.
// A subtract computes A + ~B + 1, so carry_out = 1 means A >= B.
// ---------------------------------------------------------------------------
module mp_add_sequencer
    import mp_pkg::*;
#(
    parameter int N     = MP_N,
    parameter int WORDS = MP_WORDS,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    mp_add_sequencer_if.slave    bus
);

    localparam logic [AW:0] WORDS_L = (AW+1)'(WORDS);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    state_t      state_q, state_d;
    logic        op_sub_q, op_sub_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic        rd_vld_q, rd_vld_d;     // read data arrives this cycle
    logic        carry_q, carry_d;       // inter-word carry/borrow
    logic        carry_out_q, carry_out_d;

    logic        rd_en;
    logic        wr_en;
    logic [AW:0] len_clamped;
    logic        last_wr;
    logic [N-1:0] b_eff;
    logic [N-1:0] sum;
    logic        cout;

    // Lengths beyond the RAM depth are clamped so pointers never wrap.
    assign len_clamped = (bus.len > WORDS_L) ? WORDS_L : bus.len;
    assign last_wr     = (wr_ptr_q == (len_q - PTR_ONE));

    // Subtraction is A + ~B with the initial carry preset to 1.
    assign b_eff = op_sub_q ? ~bus.b_word : bus.b_word;

    adder_cin #(.N(N)) u_adder (
        .a    (bus.a_word),
        .b    (b_eff),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        op_sub_d    = op_sub_q;
        len_d       = len_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_vld_d    = 1'b0;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        rd_en       = 1'b0;
        wr_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_sub_d = bus.op_sub;
                    len_d    = len_clamped;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    carry_d  = bus.op_sub;
                    if (len_clamped == '0) begin
                        // Empty operands: the result is just the preset carry.
                        state_d     = DONE;
                        carry_out_d = bus.op_sub;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (bus.abort) begin
                    // Cancel: no strobes this cycle, carry_out untouched.
                    state_d = IDLE;
                end else begin
                    if (rd_ptr_q < len_q) begin
                        rd_en    = 1'b1;
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        rd_vld_d = 1'b1;
                    end
                    if (rd_vld_q) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        carry_d  = cout;
                        if (last_wr) begin
                            state_d     = DONE;
                            carry_out_d = cout;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: only control state is reset; there is no local storage array,
    // the datapath words live in the external RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_sub_q    <= 1'b0;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_vld_q    <= 1'b0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_sub_q    <= op_sub_d;
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_vld_q    <= rd_vld_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
        end
    end

    // Address/data outputs are zeroed when their strobe is low so the bus
    // is quiet outside active transfers and during reset.
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_en ? rd_ptr_q[AW-1:0] : '0;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_en ? wr_ptr_q[AW-1:0] : '0;
    assign bus.wr_data   = wr_en ? sum : '0;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.carry_out = carry_out_q;

endmodule : mp_add_sequencer

// File: tb/tb_mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mp_add_sequencer
// Directed bench for mp_add_sequencer. A behavioural synchronous RAM feeds
// operand words; a per-cycle log of the DUT outputs is taken on the falling
// edge and each scenario task compares it against hand-computed values (or a
// whole-number reference sum for the full-length case).
// Cycle c of an operation is the c-th clock period after the start edge T0.
// ---------------------------------------------------------------------------
module tb_mp_add_sequencer;
    import mp_pkg::*;

    localparam int N     = MP_N;
    localparam int WORDS = MP_WORDS;
    localparam int AW    = $clog2(WORDS);
    localparam int LOGSZ = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    mp_add_sequencer_if #(.N(N), .AW(AW)) bus ();

    mp_add_sequencer #(.N(N), .WORDS(WORDS), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous scratch RAM: data valid the cycle after rd_en.
    logic [N-1:0] mem_a [WORDS];
    logic [N-1:0] mem_b [WORDS];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_word <= mem_a[bus.rd_addr];
            bus.b_word <= mem_b[bus.rd_addr];
        end
    end

    // Per-cycle observation log, index = cycle number after T0.
    logic          rd_log   [LOGSZ];
    logic          wr_log   [LOGSZ];
    logic [AW-1:0] wa_log   [LOGSZ];
    logic [N-1:0]  wd_log   [LOGSZ];
    logic          busy_log [LOGSZ];
    logic          done_log [LOGSZ];
    logic          cout_log [LOGSZ];

    logic ref_carry;

    // Called at a falling edge: presents a start for one cycle.
    task automatic start_op(input logic op, input int n);
        bus.start  = 1'b1;
        bus.op_sub = op;
        bus.len    = (AW+1)'(n);
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Records ncyc cycles of outputs. abort_cyc / start_cyc select a cycle in
    // which abort / a stray start is held high (0 = never).
    task automatic collect(input int ncyc, input int abort_cyc, input int start_cyc);
        for (int i = 0; i < LOGSZ; i++) begin
            rd_log[i] = 1'b0; wr_log[i] = 1'b0; wa_log[i] = '0; wd_log[i] = '0;
            busy_log[i] = 1'b0; done_log[i] = 1'b0; cout_log[i] = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            rd_log[c]   = bus.rd_en;
            wr_log[c]   = bus.wr_en;
            wa_log[c]   = bus.wr_addr;
            wd_log[c]   = bus.wr_data;
            busy_log[c] = bus.busy;
            done_log[c] = bus.done;
            cout_log[c] = bus.carry_out;
            bus.abort = (c + 1 == abort_cyc);
            if (c + 1 == start_cyc) begin
                bus.start  = 1'b1;
                bus.op_sub = ~bus.op_sub;
                bus.len    = (AW+1)'(1);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", bus.rd_en); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry_out got=%b exp=0", bus.carry_out); end
        checks++; if (bus.wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // A = all ones, B = 1: carry ripples through every word.
    task automatic test_add_ripple();
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 32'hFFFF_FFFF;
            mem_b[i] = (i == 0) ? 32'h1 : 32'h0;
        end
        start_op(1'b0, 4);
        collect(6, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (rd_log[c] !== (c <= 4)) begin errors++; $display("FAIL add_rd_en c%0d got=%b", c, rd_log[c]); end
            checks++;
            if (wr_log[c] !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL add_wr_en c%0d got=%b", c, wr_log[c]); end
            checks++;
            if (busy_log[c] !== (c <= 5)) begin errors++; $display("FAIL add_busy c%0d got=%b", c, busy_log[c]); end
            checks++;
            if (done_log[c] !== (c == 6)) begin errors++; $display("FAIL add_done c%0d got=%b", c, done_log[c]); end
        end
        for (int c = 2; c <= 5; c++) begin
            checks++;
            if (wa_log[c] !== AW'(c - 2)) begin errors++; $display("FAIL add_wr_addr c%0d got=%0d exp=%0d", c, wa_log[c], c - 2); end
            checks++;
            if (wd_log[c] !== 32'h0) begin errors++; $display("FAIL add_wr_data c%0d got=%h exp=00000000", c, wd_log[c]); end
        end
        checks++;
        if (cout_log[6] !== 1'b1) begin errors++; $display("FAIL add_carry_out got=%b exp=1", cout_log[6]); end
    endtask

    task automatic test_sub();
        // A = 0x1_00000000, B = 1 -> 0x0_FFFFFFFF, no borrow.
        mem_a[0] = 32'h0; mem_a[1] = 32'h1;
        mem_b[0] = 32'h1; mem_b[1] = 32'h0;
        start_op(1'b1, 2);
        collect(4, 0, 0);
        checks++; if (wa_log[2] !== AW'(0) || wd_log[2] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_w0 got=%0d:%h exp=0:ffffffff", wa_log[2], wd_log[2]); end
        checks++; if (wa_log[3] !== AW'(1) || wd_log[3] !== 32'h0) begin errors++; $display("FAIL sub_w1 got=%0d:%h exp=1:00000000", wa_log[3], wd_log[3]); end
        checks++; if (done_log[4] !== 1'b1) begin errors++; $display("FAIL sub_done got=%b exp=1", done_log[4]); end
        checks++; if (cout_log[4] !== 1'b1) begin errors++; $display("FAIL sub_carry_out got=%b exp=1", cout_log[4]); end

        // Swapped: A = 1, B = 0x1_00000000 -> borrow, result 0xFFFFFFFF_00000001.
        mem_a[0] = 32'h1; mem_a[1] = 32'h0;
        mem_b[0] = 32'h0; mem_b[1] = 32'h1;
        start_op(1'b1, 2);
        collect(4, 0, 0);
        checks++; if (wd_log[2] !== 32'h1) begin errors++; $display("FAIL subswap_w0 got=%h exp=00000001", wd_log[2]); end
        checks++; if (wd_log[3] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL subswap_w1 got=%h exp=ffffffff", wd_log[3]); end
        checks++; if (cout_log[4] !== 1'b0) begin errors++; $display("FAIL subswap_carry_out got=%b exp=0", cout_log[4]); end
    endtask

    task automatic test_len_zero();
        for (int k = 0; k < 2; k++) begin
            logic op;
            op = (k == 0);
            start_op(op, 0);
            collect(3, 0, 0);
            checks++; if (done_log[1] !== 1'b1) begin errors++; $display("FAIL len0_done op%0b got=%b exp=1", op, done_log[1]); end
            checks++; if (done_log[2] !== 1'b0) begin errors++; $display("FAIL len0_done_pulse op%0b got=%b exp=0", op, done_log[2]); end
            checks++; if (busy_log[1] !== 1'b0) begin errors++; $display("FAIL len0_busy op%0b got=%b exp=0", op, busy_log[1]); end
            checks++; if (cout_log[1] !== op) begin errors++; $display("FAIL len0_carry_out op%0b got=%b exp=%b", op, cout_log[1], op); end
            for (int c = 1; c <= 3; c++) begin
                checks++;
                if (rd_log[c] !== 1'b0 || wr_log[c] !== 1'b0) begin
                    errors++; $display("FAIL len0_strobes op%0b c%0d got rd=%b wr=%b exp=0", op, c, rd_log[c], wr_log[c]);
                end
            end
        end
    endtask

    // Full-length random add against a whole-number reference; a stray
    // start mid-run must be ignored.
    task automatic test_full_random();
        logic [N*WORDS:0] big_a, big_b, big_s;
        big_a = '0; big_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
            big_a[N*i +: N] = mem_a[i];
            big_b[N*i +: N] = mem_b[i];
        end
        big_s = big_a + big_b;
        ref_carry = big_s[N*WORDS];
        start_op(1'b0, WORDS);
        collect(WORDS + 3, 0, 10);
        for (int c = 1; c <= WORDS + 3; c++) begin
            checks++;
            if (wr_log[c] !== (c >= 2 && c <= WORDS + 1)) begin errors++; $display("FAIL full_wr_en c%0d got=%b", c, wr_log[c]); end
            checks++;
            if (busy_log[c] !== (c <= WORDS + 1)) begin errors++; $display("FAIL full_busy c%0d got=%b", c, busy_log[c]); end
            checks++;
            if (done_log[c] !== (c == WORDS + 2)) begin errors++; $display("FAIL full_done c%0d got=%b", c, done_log[c]); end
        end
        for (int c = 2; c <= WORDS + 1; c++) begin
            checks++;
            if (wa_log[c] !== AW'(c - 2) || wd_log[c] !== big_s[N*(c-2) +: N]) begin
                errors++;
                $display("FAIL full_word c%0d got=%0d:%h exp=%0d:%h", c, wa_log[c], wd_log[c], c - 2, big_s[N*(c-2) +: N]);
            end
        end
        checks++;
        if (cout_log[WORDS + 2] !== ref_carry) begin errors++; $display("FAIL full_carry_out got=%b exp=%b", cout_log[WORDS + 2], ref_carry); end
    endtask

    task automatic test_abort();
        start_op(1'b0, 8);
        collect(3, 3, 0);
        checks++; if (wr_log[2] !== 1'b1) begin errors++; $display("FAIL abort_pre_write got=%b exp=1", wr_log[2]); end
        checks++; if (wr_log[3] !== 1'b0 || rd_log[3] !== 1'b0) begin errors++; $display("FAIL abort_strobes got rd=%b wr=%b exp=0", rd_log[3], wr_log[3]); end
        checks++; if (cout_log[3] !== ref_carry) begin errors++; $display("FAIL abort_carry_hold got=%b exp=%b", cout_log[3], ref_carry); end
        // Now in cycle 4: must be idle with no done pulse.
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", bus.done); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL abort_no_wr got=%b exp=0", bus.wr_en); end
        checks++; if (bus.carry_out !== ref_carry) begin errors++; $display("FAIL abort_carry_keep got=%b exp=%b", bus.carry_out, ref_carry); end

        // Restart immediately with the no-borrow subtract vector.
        mem_a[0] = 32'h0; mem_a[1] = 32'h1;
        mem_b[0] = 32'h1; mem_b[1] = 32'h0;
        start_op(1'b1, 2);
        collect(4, 0, 0);
        checks++; if (done_log[1] !== 1'b0) begin errors++; $display("FAIL restart_stale_done got=%b exp=0", done_log[1]); end
        checks++; if (wd_log[2] !== 32'hFFFF_FFFF || wd_log[3] !== 32'h0) begin errors++; $display("FAIL restart_data got=%h,%h exp=ffffffff,00000000", wd_log[2], wd_log[3]); end
        checks++; if (done_log[4] !== 1'b1 || cout_log[4] !== 1'b1) begin errors++; $display("FAIL restart_done got done=%b cout=%b exp=1,1", done_log[4], cout_log[4]); end
    endtask

    task automatic test_reset_mid();
        int late_writes;
        mem_a[0] = 32'h0; mem_a[1] = 32'h1;
        start_op(1'b0, 8);
        collect(3, 0, 0);
        // Cycle 4 of a len=8 add: a write is in flight.
        checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre_wr got=%b exp=1", bus.wr_en); end
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got=%b exp=0", bus.wr_en); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got=%b exp=0", bus.rd_en); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL rstmid_carry_out got=%b exp=0", bus.carry_out); end
        @(negedge clk);
        rst = 1'b1;
        collect(12, 0, 0);
        late_writes = 0;
        for (int c = 1; c <= 12; c++) begin
            if (wr_log[c] || busy_log[c] || done_log[c]) late_writes++;
        end
        checks++; if (late_writes !== 0) begin errors++; $display("FAIL rstmid_activity_after_release got=%0d exp=0", late_writes); end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.len    = '0;
        bus.abort  = 1'b0;
        ref_carry  = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        test_reset();
        test_add_ripple();
        test_sub();
        test_len_zero();
        test_full_random();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mp_add_sequencer
